// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default sizing for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    REDIR_PEND = 2'd2
  } pc_state_t;

  localparam int DEF_NUM_REGS  = 4;
  localparam int DEF_HAZ_REG   = 1;
  localparam int DEF_FLUSH_CNT = 2;
  localparam int DEF_CNT_W     = 32;

  // Per-register control word at the default pipeline depth; the top module
  // declares the same layout sized by its own NUM_REGS.
  typedef struct packed {
    logic [DEF_NUM_REGS-1:0] ld;
    logic [DEF_NUM_REGS-1:0] flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  // Count enabled cycles, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (en) count <= sat_inc(count);
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Central stall/flush controller: arbitrates cache stalls, load-use bubbles
// and EX redirects into PC load/select and per-register load/flush vectors.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int HAZ_REG   = DEF_HAZ_REG,
  parameter int FLUSH_CNT = DEF_FLUSH_CNT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_stall,
  input  logic                dmem_stall,
  input  logic                load_use,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic                pc_ld,
  output logic                pc_sel_redirect,
  output logic [31:0]         pc_target,
  output logic [NUM_REGS-1:0] reg_ld,
  output logic [NUM_REGS-1:0] reg_flush,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    flush_events
);

  typedef struct packed {
    logic [NUM_REGS-1:0] ld;
    logic [NUM_REGS-1:0] flush;
  } ctrl_t;

  localparam logic [NUM_REGS-1:0] ALL_ONES   = '1;
  localparam logic [NUM_REGS-1:0] FLUSH_MASK = NUM_REGS'((1 << FLUSH_CNT) - 1);
  localparam logic [NUM_REGS-1:0] YOUNG_MASK = NUM_REGS'((1 << HAZ_REG) - 1);
  localparam logic [NUM_REGS-1:0] HAZ_BIT    = NUM_REGS'(1) << HAZ_REG;
  localparam logic [NUM_REGS-1:0] IFID_BIT   = NUM_REGS'(1);

  pc_state_t   state_q, state_d;
  logic [31:0] held_q, held_d;
  ctrl_t       ctrl;
  logic        flush_inc;

  // State and pending redirect target; reset drops any held target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  // Priority arbitration: dmem freeze, redirect under imem miss, pending
  // redirect, live redirect, imem bubble, load-use bubble, free run.
  always_comb begin
    state_d         = RUN;
    held_d          = held_q;
    ctrl.ld         = ALL_ONES;
    ctrl.flush      = '0;
    pc_ld           = 1'b0;
    pc_sel_redirect = 1'b0;
    pc_target       = redirect_pc;
    flush_inc       = 1'b0;
    if (!rst_n) begin
      ctrl.ld   = '0;
      pc_target = '0;
    end else if (dmem_stall) begin
      // Redirect and load_use re-present once memory releases the pipe.
      ctrl.ld = '0;
      state_d = (state_q == REDIR_PEND) ? REDIR_PEND : MEM_WAIT;
    end else if (redirect && imem_stall && state_q != REDIR_PEND) begin
      // The outstanding fetch cannot be aborted, so park the target.
      ctrl.flush = FLUSH_MASK;
      held_d     = redirect_pc;
      state_d    = REDIR_PEND;
      flush_inc  = 1'b1;
    end else if (state_q == REDIR_PEND) begin
      ctrl.flush = IFID_BIT;
      if (redirect) begin
        ctrl.flush = FLUSH_MASK;
        held_d     = redirect_pc;
        flush_inc  = 1'b1;
      end
      if (imem_stall) begin
        state_d = REDIR_PEND;
      end else begin
        // Fetched word is wrong path; steer PC to the newest target.
        pc_ld           = 1'b1;
        pc_sel_redirect = 1'b1;
        pc_target       = redirect ? redirect_pc : held_q;
      end
    end else if (redirect) begin
      pc_ld           = 1'b1;
      pc_sel_redirect = 1'b1;
      ctrl.flush      = FLUSH_MASK;
      flush_inc       = 1'b1;
    end else if (imem_stall) begin
      if (load_use) begin
        ctrl.ld    = ALL_ONES & ~YOUNG_MASK;
        ctrl.flush = HAZ_BIT;
      end else begin
        ctrl.flush = IFID_BIT;
      end
    end else if (load_use) begin
      ctrl.ld    = ALL_ONES & ~YOUNG_MASK;
      ctrl.flush = HAZ_BIT;
    end else begin
      pc_ld = 1'b1;
    end
  end

  assign reg_ld    = ctrl.ld;
  assign reg_flush = ctrl.flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!pc_ld),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_inc),
    .count (flush_events)
  );

  // Parameter legality and PC/hold consistency.
  a_flush_cnt: assert property (@(posedge clk) FLUSH_CNT < NUM_REGS);
  a_haz_reg:   assert property (@(posedge clk) HAZ_REG < NUM_REGS);
  a_pc_hold:   assert property (@(posedge clk) disable iff (!rst_n)
                                pc_ld |-> (&reg_ld[HAZ_REG-1:0]));

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed-vector bench for pipe_ctrl_unit (32-bit and 4-bit counter builds).
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_stall = 1'b0, dmem_stall = 1'b0, load_use = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        pc_ld, pc_sel_redirect, pc_ld4, pc_sel4;
  logic [31:0] pc_target, pc_target4;
  logic [3:0]  reg_ld, reg_flush, reg_ld4, reg_flush4;
  logic [31:0] stall_cycles, flush_events;
  logic [3:0]  stall4, flush4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.NUM_REGS(4), .HAZ_REG(1), .FLUSH_CNT(2), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .load_use(load_use), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_ld(pc_ld), .pc_sel_redirect(pc_sel_redirect), .pc_target(pc_target),
    .reg_ld(reg_ld), .reg_flush(reg_flush),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipe_ctrl_unit #(.NUM_REGS(4), .HAZ_REG(1), .FLUSH_CNT(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .load_use(load_use), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_ld(pc_ld4), .pc_sel_redirect(pc_sel4), .pc_target(pc_target4),
    .reg_ld(reg_ld4), .reg_flush(reg_flush4),
    .stall_cycles(stall4), .flush_events(flush4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a cycle's inputs just after the rising edge, leave time to settle.
  task automatic drive(input logic im, input logic dm, input logic lu, input logic rd,
                       input logic [31:0] pc);
    imem_stall = im; dmem_stall = dm; load_use = lu; redirect = rd; redirect_pc = pc;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic pl, input logic ps,
                          input logic [3:0] ld, input logic [3:0] fl);
    chk({tag, ".pc_ld"}, {31'd0, pc_ld}, {31'd0, pl});
    chk({tag, ".sel"},   {31'd0, pc_sel_redirect}, {31'd0, ps});
    chk({tag, ".ld"},    {28'd0, reg_ld}, {28'd0, ld});
    chk({tag, ".flush"}, {28'd0, reg_flush}, {28'd0, fl});
  endtask

  initial begin
    // Reset: 3 cycles, outputs forced low.
    drive(0, 0, 0, 0, 32'h0);
    repeat (3) next_cycle();
    chk_ctrl("rst", 0, 0, 4'b0000, 4'b0000);
    chk("rst.target", pc_target, 32'h0);
    chk("rst.stall", stall_cycles, 32'd0);
    chk("rst.flushev", flush_events, 32'd0);
    rst_n = 1'b1;

    // Free run.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 32'h0);
      chk_ctrl("run", 1, 0, 4'b1111, 4'b0000);
      next_cycle();
    end
    chk("run.stall", stall_cycles, 32'd0);
    chk("run.flushev", flush_events, 32'd0);

    // Load-use bubble.
    drive(0, 0, 1, 0, 32'h0);
    chk_ctrl("lu", 0, 0, 4'b1110, 4'b0010);
    next_cycle();
    chk("lu.stall", stall_cycles, 32'd1);

    // dmem freeze with redirect appearing mid-stall.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, (i >= 2), 32'h0000_0100);
      chk_ctrl("dmem", 0, 0, 4'b0000, 4'b0000);
      next_cycle();
    end
    chk("dmem.flushev", flush_events, 32'd0);
    chk("dmem.stall", stall_cycles, 32'd6);
    drive(0, 0, 0, 1, 32'h0000_0100);
    chk_ctrl("dmem_rel", 1, 1, 4'b1111, 4'b0011);
    chk("dmem_rel.target", pc_target, 32'h0000_0100);
    next_cycle();
    chk("dmem_rel.flushev", flush_events, 32'd1);

    // Redirect during i-cache miss, released after 3 stalled cycles.
    drive(1, 0, 0, 1, 32'h0000_0840);
    chk_ctrl("imr", 0, 0, 4'b1111, 4'b0011);
    next_cycle();
    chk("imr.flushev", flush_events, 32'd2);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 32'h0000_0000);
      chk_ctrl("pend", 0, 0, 4'b1111, 4'b0001);
      next_cycle();
    end
    drive(0, 0, 0, 0, 32'h0000_0000);
    chk_ctrl("pend_rel", 1, 1, 4'b1111, 4'b0001);
    chk("pend_rel.target", pc_target, 32'h0000_0840);
    next_cycle();
    drive(0, 0, 0, 0, 32'h0000_0000);
    chk_ctrl("after_pend", 1, 0, 4'b1111, 4'b0000);
    next_cycle();
    chk("pend.stall", stall_cycles, 32'd9);
    chk("pend.flushev", flush_events, 32'd2);

    // Redirect outranks load_use.
    drive(0, 0, 1, 1, 32'h0000_0200);
    chk_ctrl("rd_lu", 1, 1, 4'b1111, 4'b0011);
    chk("rd_lu.target", pc_target, 32'h0000_0200);
    next_cycle();

    // i-cache miss together with load_use: hazard bubble replaces IF/ID bubble.
    drive(1, 0, 1, 0, 32'h0);
    chk_ctrl("im_lu", 0, 0, 4'b1110, 4'b0010);
    next_cycle();
    chk("mix.stall", stall_cycles, 32'd10);
    chk("mix.flushev", flush_events, 32'd3);
    chk("mix.stall4", {28'd0, stall4}, 32'd10);

    // Saturation of the 4-bit stall counter.
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 0, 32'h0);
      next_cycle();
    end
    chk("sat.stall4", {28'd0, stall4}, 32'd15);
    chk("sat.stall32", stall_cycles, 32'd30);
    chk("sat.flush4", {28'd0, flush4}, 32'd3);

    // Enter REDIR_PEND, then reset mid-cycle: held target must vanish.
    drive(1, 0, 0, 1, 32'h0000_0999);
    next_cycle();
    drive(1, 0, 0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_ctrl("arst", 0, 0, 4'b0000, 4'b0000);
    chk("arst.target", pc_target, 32'h0);
    chk("arst.stall", stall_cycles, 32'd0);
    chk("arst.flushev4", {28'd0, flush4}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    chk_ctrl("post_rst", 1, 0, 4'b1111, 4'b0000);
    next_cycle();
    chk("post_rst.stall", stall_cycles, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
